// File: rtl/gp_countn_adv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gp_count_defs (package)
//  Description : Shared definitions for the parametrised GreenPAK-style
//                counter cells: RESET_VALUE selector strings, parameter
//                legality limits and a ceil(log2) helper for sizing
//                prescaler counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package gp_count_defs;

    // Selector strings accepted by the RESET_VALUE parameter
    localparam string c_rv_zero     = "ZERO";
    localparam string c_rv_count_to = "COUNT_TO";

    // Legality limits
    localparam int c_width_min  = 2;
    localparam int c_width_max  = 16;
    localparam int c_divide_min = 1;
    localparam int c_divide_max = 256;

    // ceil(log2(n)); 0 for n <= 1
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of a 0..n-1 counter, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage : gp_count_defs
`default_nettype wire

// File: rtl/gp_countn_adv_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : gp_prescaler
//  Description : Free-running divide-by-DIVIDE prescaler. TICK is high during
//                the last CLK cycle of every DIVIDE-cycle window, so a
//                consumer sampling it on the rising edge advances once per
//                DIVIDE edges. With DIVIDE=1 TICK is constantly high.
//  Ports       : CLK  - rising-edge clock
//                RST  - asynchronous active-high reset (clears the phase)
//                TICK - enable for the consumer, combinational from phase
//  Revision    : 1.0 - initial release
// ============================================================================
module gp_prescaler
    import gp_count_defs::*;
#(
    parameter int DIVIDE = 1
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int              c_pw   = cnt_width(DIVIDE);
    localparam logic [c_pw-1:0] c_last = c_pw'(DIVIDE - 1);
    localparam logic [c_pw-1:0] c_one  = c_pw'(1);

    logic [c_pw-1:0] r_pcnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pcnt <= '0;
        end else if (TICK) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + c_one;
        end
    end

    assign TICK = (r_pcnt == c_last);

endmodule : gp_prescaler
`default_nettype wire

// File: rtl/gp_countn_adv.sv
`default_nettype none
// ============================================================================
//  Module      : gp_countn_adv
//  Description : Parametrised up/down counter with hold, CLKIN_DIVIDE
//                prescaler and optional one-shot stop at terminal count.
//                Terminal count is all-ones when counting up, zero when
//                counting down; ordinary mode reloads COUNT_TO there.
//  Ports       : CLK  - rising-edge clock
//                RST  - asynchronous active-high reset
//                UP   - 1 = count up, 0 = count down
//                KEEP - 1 = hold count (prescaler keeps running)
//                OUT  - terminal-count flag, combinational (follows UP)
//                POUT - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module gp_countn_adv
    import gp_count_defs::*;
#(
    parameter int    WIDTH        = 14,
    parameter int    COUNT_TO     = 1,
    parameter int    CLKIN_DIVIDE = 1,
    parameter string RESET_VALUE  = "ZERO",
    parameter int    ONE_SHOT     = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP,
    input  logic             KEEP,
    output logic             OUT,
    output logic [WIDTH-1:0] POUT
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (WIDTH < c_width_min || WIDTH > c_width_max) begin : g_bad_width
        $fatal(1, "gp_countn_adv: WIDTH=%0d outside %0d..%0d", WIDTH, c_width_min, c_width_max);
    end
    if (CLKIN_DIVIDE < c_divide_min || CLKIN_DIVIDE > c_divide_max) begin : g_bad_divide
        $fatal(1, "gp_countn_adv: CLKIN_DIVIDE=%0d outside %0d..%0d", CLKIN_DIVIDE, c_divide_min, c_divide_max);
    end
    if (RESET_VALUE != c_rv_zero && RESET_VALUE != c_rv_count_to) begin : g_bad_reset_value
        $fatal(1, "gp_countn_adv: RESET_VALUE must be \"ZERO\" or \"COUNT_TO\"");
    end
    if (COUNT_TO < 0 || COUNT_TO > ((1 << WIDTH) - 1)) begin : g_bad_count_to
        $fatal(1, "gp_countn_adv: COUNT_TO=%0d does not fit in %0d bits", COUNT_TO, WIDTH);
    end

    localparam logic [WIDTH-1:0] c_max      = '1;
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_count_to = WIDTH'(COUNT_TO);
    localparam logic [WIDTH-1:0] c_rst_val  = (RESET_VALUE == c_rv_count_to) ? c_count_to : '0;
    localparam bit               c_one_shot = (ONE_SHOT != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_stopped;
    logic             w_tick;
    logic             w_at_term;

    gp_prescaler #(
        .DIVIDE (CLKIN_DIVIDE)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (w_tick)
    );

    // Terminal comparator depends on the live direction input, so OUT can
    // change between clock edges when UP toggles.
    assign w_at_term = UP ? (r_count == c_max) : (r_count == '0);

    // KEEP outranks everything, including the terminal reload and the
    // one-shot stop; a held tick is simply lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count   <= c_rst_val;
            r_stopped <= 1'b0;
        end else if (w_tick && !KEEP && !(c_one_shot && r_stopped)) begin
            if (w_at_term) begin
                if (c_one_shot) begin
                    r_stopped <= 1'b1;
                end else begin
                    r_count <= c_count_to;
                end
            end else if (UP) begin
                r_count <= r_count + c_one;
            end else begin
                r_count <= r_count - c_one;
            end
        end
    end

    assign OUT  = w_at_term;
    assign POUT = r_count;

endmodule : gp_countn_adv
`default_nettype wire
